wb_commit_unit: RTL and testbench

- Writeback end of the MEM/WB pipeline interface: consumes the W-stage bundle and commits it to architectural state.
- Extracts and extends sub-word load data, drives the register-file write port, and owns the HI/LO register pair.
- Exports bypassed HI/LO and the W-stage result for forwarding to ID/EX.

---
 rtl/wb_commit_unit.sv | 122 ++++++++++++
 tb/tb_wb_commit_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Writeback commit stage: sub-word load extraction, GPR write port, HI/LO pair with
// same-cycle bypass. Define WB_RETIRE_CNT_EN to build the retired-instruction counter.
module wb_commit_unit #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validW,
  input  logic            RegWriteW,
  input  logic            MemtoRegW,
  input  logic            hilowriteW,
  input  logic [2:0]      loadtypeW,
  input  logic [DW-1:0]   aluoutW,
  input  logic [DW-1:0]   readdataW,
  input  logic [2*DW-1:0] hiloresW,
  input  logic [RW-1:0]   writeregW,
  output logic            rf_we,
  output logic [RW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [DW-1:0]   resultW,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o,
  output logic            adel_o,
  output logic [31:0]     retire_cnt
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  logic [1:0]    addr;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;
  logic          misaligned;
  logic          hilo_wr;

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          adel_q, adel_d;

  assign addr    = aluoutW[1:0];
  assign hilo_wr = validW & hilowriteW;

  // Reserved load types decode exactly like LW, including the alignment rule.
  always_comb begin
    ld_byte = readdataW[{addr, 3'b000} +: 8];
    ld_half = addr[1] ? readdataW[31:16] : readdataW[15:0];
    ld_data = readdataW;
    case (loadtypeW)
      LT_LB:   ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
      LT_LBU:  ld_data = {{(DW-8){1'b0}}, ld_byte};
      LT_LH:   ld_data = {{(DW-16){ld_half[15]}}, ld_half};
      LT_LHU:  ld_data = {{(DW-16){1'b0}}, ld_half};
      default: ld_data = readdataW;
    endcase
  end

  // Alignment only matters when the result actually comes from memory.
  always_comb begin
    misaligned = 1'b0;
    if (MemtoRegW) begin
      case (loadtypeW)
        LT_LB, LT_LBU: misaligned = 1'b0;
        LT_LH, LT_LHU: misaligned = addr[0];
        default:       misaligned = (addr != 2'b00);
      endcase
    end
  end

  assign resultW  = MemtoRegW ? ld_data : aluoutW;
  assign rf_wdata = resultW;
  assign rf_waddr = writeregW;
  assign rf_we    = validW & RegWriteW & (writeregW != '0) & ~misaligned & reset;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    adel_d = validW & misaligned;
    if (hilo_wr) begin
      hi_d = hiloresW[2*DW-1:DW];
      lo_d = hiloresW[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      adel_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      adel_q <= adel_d;
    end
  end

  assign hi_o   = hilo_wr ? hiloresW[2*DW-1:DW] : hi_q;
  assign lo_o   = hilo_wr ? hiloresW[DW-1:0]    : lo_q;
  assign adel_o = adel_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (validW && !misaligned) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed plus randomized bench for wb_commit_unit against a behavioural model.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        validW, RegWriteW, MemtoRegW, hilowriteW;
  logic [2:0]  loadtypeW;
  logic [31:0] aluoutW, readdataW;
  logic [63:0] hiloresW;
  logic [4:0]  writeregW;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, resultW, hi_o, lo_o;
  logic        adel_o;
  logic [31:0] retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hi_m, lo_m, cnt_m;
  logic        adel_m;

  wb_commit_unit dut (
    .clk(clk), .reset(reset), .validW(validW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .hilowriteW(hilowriteW), .loadtypeW(loadtypeW),
    .aluoutW(aluoutW), .readdataW(readdataW), .hiloresW(hiloresW),
    .writeregW(writeregW), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .resultW(resultW), .hi_o(hi_o), .lo_o(lo_o),
    .adel_o(adel_o), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    int unsigned off;
    off = a % 4;
    b = (rd >> (off * 8)) & 32'hFF;
    h = (rd >> ((off / 2) * 16)) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic model_mis(input logic m2r, input logic [2:0] lt, input logic [31:0] a);
    if (!m2r) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return 1'b0;
    if (lt == 3'd3 || lt == 3'd4) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic rw, input logic m2r,
                       input logic hw, input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [63:0] hl, input logic [4:0] wr);
    reset = rst; validW = v; RegWriteW = rw; MemtoRegW = m2r; hilowriteW = hw;
    loadtypeW = lt; aluoutW = alu; readdataW = rd; hiloresW = hl; writeregW = wr;
  endtask

  task automatic sample();
    logic        mis, we_e;
    logic [31:0] res, cnt_e;
    @(negedge clk);
    mis  = model_mis(MemtoRegW, loadtypeW, aluoutW);
    res  = MemtoRegW ? model_load(loadtypeW, aluoutW, readdataW) : aluoutW;
    we_e = validW && RegWriteW && (writeregW != 0) && !mis && reset;
`ifdef WB_RETIRE_CNT_EN
    cnt_e = cnt_m;
`else
    cnt_e = 32'd0;
`endif
    chk("rf_we",      {31'd0, rf_we}, {31'd0, we_e});
    chk("rf_waddr",   {27'd0, rf_waddr}, {27'd0, writeregW});
    chk("rf_wdata",   rf_wdata, res);
    chk("resultW",    resultW, res);
    chk("hi_o",       hi_o, (validW && hilowriteW) ? hiloresW[63:32] : hi_m);
    chk("lo_o",       lo_o, (validW && hilowriteW) ? hiloresW[31:0]  : lo_m);
    chk("adel_o",     {31'd0, adel_o}, {31'd0, adel_m});
    chk("retire_cnt", retire_cnt, cnt_e);
  endtask

  task automatic commit();
    logic mis;
    @(posedge clk);
    mis = model_mis(MemtoRegW, loadtypeW, aluoutW);
    if (!reset) begin
      hi_m = 0; lo_m = 0; adel_m = 0; cnt_m = 0;
    end else begin
      adel_m = validW && mis;
      if (validW && hilowriteW) begin
        hi_m = hiloresW[63:32];
        lo_m = hiloresW[31:0];
      end
      if (validW && !mis) cnt_m = cnt_m + 1;
    end
    #1;
  endtask

  initial begin
    hi_m = 0; lo_m = 0; cnt_m = 0; adel_m = 0;

    // Reset held two edges while a HI/LO write is requested.
    drive(0, 1, 1, 0, 1, 3'd0, 32'h0, 32'h0, 64'hDEADBEEF_12345678, 5'd3);
    @(posedge clk); #1;
    sample(); chk("rst_rf_we", {31'd0, rf_we}, 32'd0); commit();
    drive(1, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 64'h0, 5'd0);
    sample(); chk("rst_hi", hi_o, 32'd0); chk("rst_lo", lo_o, 32'd0); commit();

    drive(1, 1, 1, 1, 0, 3'd1, 32'h1003, 32'h80FF7F01, 64'h0, 5'd8);
    sample();
    chk("lb_we", {31'd0, rf_we}, 32'd1);
    chk("lb_waddr", {27'd0, rf_waddr}, 32'd8);
    chk("lb_data", rf_wdata, 32'hFFFFFF80);
    commit();
    drive(1, 1, 1, 1, 0, 3'd2, 32'h1003, 32'h80FF7F01, 64'h0, 5'd8);
    sample(); chk("lbu_data", rf_wdata, 32'h00000080); commit();

    drive(1, 1, 1, 1, 0, 3'd3, 32'h2002, 32'h80011234, 64'h0, 5'd9);
    sample(); chk("lh_data", rf_wdata, 32'hFFFF8001); commit();
    drive(1, 1, 1, 1, 0, 3'd3, 32'h2002, 32'h80011234, 64'h0, 5'd0);
    sample(); chk("lh_r0_we", {31'd0, rf_we}, 32'd0); commit();

    // Same-cycle bypass, then hold.
    drive(1, 1, 1, 0, 1, 3'd0, 32'h55, 32'h0, 64'h00000005_0000000A, 5'd4);
    sample(); chk("byp_hi", hi_o, 32'd5); chk("byp_lo", lo_o, 32'hA); commit();
    drive(1, 1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0);
    sample(); chk("hold_hi", hi_o, 32'd5); chk("hold_lo", lo_o, 32'hA); commit();

    drive(1, 1, 1, 1, 0, 3'd0, 32'h3001, 32'h12345678, 64'h0, 5'd7);
    sample(); chk("mis_we", {31'd0, rf_we}, 32'd0); chk("mis_adel_pre", {31'd0, adel_o}, 32'd0);
    commit();
    drive(1, 1, 1, 0, 0, 3'd0, 32'h3000, 32'h0, 64'h0, 5'd7);
    sample(); chk("mis_adel_next", {31'd0, adel_o}, 32'd1); commit();
    sample(); chk("mis_adel_clear", {31'd0, adel_o}, 32'd0); commit();

    // Bubble with every write requested: nothing may commit.
    drive(1, 0, 1, 1, 1, 3'd0, 32'h4001, 32'h0, 64'h11111111_22222222, 5'd6);
    sample(); chk("bub_we", {31'd0, rf_we}, 32'd0); chk("bub_hi", hi_o, 32'd5); commit();
    sample(); chk("bub_adel", {31'd0, adel_o}, 32'd0); chk("bub_lo", lo_o, 32'hA); commit();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            $urandom, $urandom, {$urandom, $urandom}, 5'($urandom));
      sample();
      commit();
    end

    drive(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 64'h0, 5'd0);
    sample(); commit();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 0, 0, 3'd0, 32'(i), 32'h0, 64'h0, 5'd2);
      sample();
      commit();
    end
    drive(1, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 64'h0, 5'd0);
    sample();
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_ten", retire_cnt, 32'd10);
`else
    chk("cnt_tied", retire_cnt, 32'd0);
`endif
    commit();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
